// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle main control unit.
//
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It drives the
// datapath write enables, the mux selects and the ALU operation code. It also owns the
// memory request handshake, including a wait watchdog, and the terminal HALT state.
//
// Parameters:
//   MEM_TIMEOUT  maximum wait cycles allowed per memory request (1..255)
//
// Ports:
//   clk, rst                  clock (rising edge) and asynchronous active-high reset
//   opcode[5:0]               instruction bits [31:26], valid from DECODE onward
//   flag_n, flag_z            registered ALU flags, sampled in EXEC only
//   mem_ready                 memory completes the current request this cycle
//   alu_op[5:0]               opcode in EXEC, 6'b111111 otherwise
//   ir_write, pc_write,
//   reg_write, sp_write       register write enables
//   pc_sel[1:0]               00 PC+1, 01 ALU result, 10 memory data
//   wb_sel[1:0]               00 ALU result, 01 memory data, 10 PC
//   sp_dec                    with sp_write: 1 = SP-1, 0 = SP+1
//   mem_req, mem_we           memory request and write strobe
//   addr_sel[1:0]             00 PC, 01 ALU result, 10 SP
//   halted                    HALT state reached
//   err[1:0]                  sticky: 00 none, 01 memory timeout, 10 illegal opcode
//
// Build option:
//   MAIN_CTRL_ILLEGAL_TRAP_EN  if defined, an unknown opcode halts with err = 10;
//                              otherwise it behaves as a NOP and returns to FETCH.

module main_control_fsm #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       mem_ready,
    output logic [5:0] alu_op,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       sp_write,
    output logic [1:0] pc_sel,
    output logic [1:0] wb_sel,
    output logic       sp_dec,
    output logic       mem_req,
    output logic       mem_we,
    output logic [1:0] addr_sel,
    output logic       halted,
    output logic [1:0] err
);

    localparam logic [5:0] OpAluLast = 6'b001001;  // 000000..001001: R-type and ALU-imm
    localparam logic [5:0] OpLd      = 6'b001010;
    localparam logic [5:0] OpSt      = 6'b001011;
    localparam logic [5:0] OpLdsp    = 6'b001100;
    localparam logic [5:0] OpStsp    = 6'b001101;
    localparam logic [5:0] OpBr      = 6'b001110;
    localparam logic [5:0] OpBmi     = 6'b001111;
    localparam logic [5:0] OpBpl     = 6'b010000;
    localparam logic [5:0] OpBz      = 6'b010001;
    localparam logic [5:0] OpPush    = 6'b010010;
    localparam logic [5:0] OpPop     = 6'b010011;
    localparam logic [5:0] OpCall    = 6'b010100;
    localparam logic [5:0] OpRet     = 6'b010101;
    localparam logic [5:0] OpMove    = 6'b010110;
    localparam logic [5:0] OpHalt    = 6'b100000;

    // Counter value during the last permitted wait cycle.
    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic [1:0] err_q, err_d;

    logic is_alu, is_ldst, is_branch, is_load, is_store;
    logic is_push, is_pop, is_call, is_ret, uses_sp, timeout;

    assign is_alu    = (opcode <= OpAluLast) || (opcode == OpMove);
    assign is_ldst   = (opcode >= OpLd) && (opcode <= OpStsp);
    assign is_branch = (opcode >= OpBr) && (opcode <= OpBz);
    assign is_load   = (opcode == OpLd) || (opcode == OpLdsp);
    assign is_store  = (opcode == OpSt) || (opcode == OpStsp);
    assign is_push   = (opcode == OpPush);
    assign is_pop    = (opcode == OpPop);
    assign is_call   = (opcode == OpCall);
    assign is_ret    = (opcode == OpRet);
    assign uses_sp   = is_push || is_pop || is_call || is_ret;
    // Completion in the final wait cycle beats the watchdog.
    assign timeout   = (wait_q == WaitLast) && !mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
            wait_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        alu_op    = 6'b111111;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        sp_write  = 1'b0;
        pc_sel    = 2'b00;
        wb_sel    = 2'b00;
        sp_dec    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 2'b00;
        halted    = 1'b0;
        err       = err_q;

        // Holding every output at its reset value while rst is high drops a pending
        // request immediately instead of at the next clock edge.
        if (!rst) begin
            unique case (state_q)
                StFetch: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StDecode;
                    end else if (timeout) begin
                        err_d   = 2'b01;
                        state_d = StHalt;
                    end
                end
                StDecode: begin
                    if (is_alu || is_ldst || is_branch || is_push || is_call) begin
                        state_d = StExec;
                    end else if (is_pop || is_ret) begin
                        state_d = StMem;
                    end else if (opcode == OpHalt) begin
                        state_d = StHalt;
                    end else begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                        err_d   = 2'b10;
                        state_d = StHalt;
`else
                        state_d = StFetch;
`endif
                    end
                end
                StExec: begin
                    alu_op = opcode;
                    if (is_branch) begin
                        pc_sel = 2'b01;
                        case (opcode)
                            OpBr:    pc_write = 1'b1;
                            OpBmi:   pc_write = flag_n;
                            OpBpl:   pc_write = !flag_n && !flag_z;
                            OpBz:    pc_write = flag_z;
                            default: pc_write = 1'b0;
                        endcase
                        state_d = StFetch;
                    end else if (is_ldst) begin
                        state_d = StMem;
                    end else if (is_push || is_call) begin
                        sp_write = 1'b1;
                        sp_dec   = 1'b1;
                        state_d  = StMem;
                    end else if (is_alu) begin
                        state_d = StWb;
                    end else begin
                        state_d = StFetch;
                    end
                end
                StMem: begin
                    mem_req  = 1'b1;
                    addr_sel = uses_sp ? 2'b10 : 2'b01;
                    mem_we   = is_store || is_push || is_call;
                    if (is_call) begin
                        pc_sel = 2'b01;
                    end
                    if (mem_ready) begin
                        if (is_load || is_pop || is_ret) begin
                            state_d = StWb;
                        end else begin
                            pc_write = is_call;
                            state_d  = StFetch;
                        end
                    end else if (timeout) begin
                        err_d   = 2'b01;
                        state_d = StHalt;
                    end
                end
                StWb: begin
                    reg_write = !is_ret;
                    wb_sel    = (is_load || is_pop) ? 2'b01 : 2'b00;
                    if (is_pop || is_ret) begin
                        sp_write = 1'b1;
                    end
                    if (is_ret) begin
                        pc_write = 1'b1;
                        pc_sel   = 2'b10;
                    end
                    state_d = StFetch;
                end
                StHalt: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = StFetch;
                end
            endcase
        end

        // Count wait cycles of a request still pending; any state change clears it.
        if ((state_d == state_q) && mem_req && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = 8'd0;
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm (MEM_TIMEOUT = 4). Each task queues one entry
// per clock cycle: the stimulus for that cycle plus the expected outputs and a care mask.
// The task then drains the queue, driving and comparing cycle by cycle.

module tb_main_control_fsm;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       sp_write;
        logic [1:0] pc_sel;
        logic [1:0] wb_sel;
        logic       sp_dec;
        logic       mem_req;
        logic       mem_we;
        logic [1:0] addr_sel;
        logic       halted;
        logic [1:0] err;
    } outs_t;

    typedef struct packed {
        logic [5:0] op;
        logic       ready;
        logic       n;
        logic       z;
        outs_t      exp;
        outs_t      care;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       flag_n, flag_z, mem_ready;
    logic [5:0] alu_op;
    logic       ir_write, pc_write, reg_write, sp_write;
    logic [1:0] pc_sel, wb_sel;
    logic       sp_dec, mem_req, mem_we;
    logic [1:0] addr_sel;
    logic       halted;
    logic [1:0] err;

    ent_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    const outs_t All = '1;

    main_control_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .mem_ready (mem_ready),
        .alu_op    (alu_op),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .reg_write (reg_write),
        .sp_write  (sp_write),
        .pc_sel    (pc_sel),
        .wb_sel    (wb_sel),
        .sp_dec    (sp_dec),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .halted    (halted),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic outs_t base_v(input logic [1:0] e);
        outs_t v = '0;
        v.alu_op = 6'b111111;
        v.err    = e;
        return v;
    endfunction

    function automatic outs_t fetch_v(input logic ready);
        outs_t v = base_v(2'b00);
        v.mem_req  = 1'b1;
        v.ir_write = ready;
        v.pc_write = ready;
        return v;
    endfunction

    function automatic outs_t observe();
        outs_t v;
        v.alu_op    = alu_op;
        v.ir_write  = ir_write;
        v.pc_write  = pc_write;
        v.reg_write = reg_write;
        v.sp_write  = sp_write;
        v.pc_sel    = pc_sel;
        v.wb_sel    = wb_sel;
        v.sp_dec    = sp_dec;
        v.mem_req   = mem_req;
        v.mem_we    = mem_we;
        v.addr_sel  = addr_sel;
        v.halted    = halted;
        v.err       = err;
        return v;
    endfunction

    function automatic void push(input logic [5:0] op, input logic r, input logic n,
                                 input logic z, input outs_t e, input outs_t c);
        ent_t t;
        t.op    = op;
        t.ready = r;
        t.n     = n;
        t.z     = z;
        t.exp   = e;
        t.care  = c;
        sb_q.push_back(t);
    endfunction

    // Tasks are entered and left 1 time unit after a rising edge.
    task automatic test_reset();
        outs_t got;
        rst = 1'b1; opcode = 6'b000000; mem_ready = 1'b1; flag_n = 1'b0; flag_z = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = observe();
        n_checks++;
        if (got !== base_v(2'b00)) begin
            n_errors++;
            $display("FAIL reset_values: got %h, expected %h", got, base_v(2'b00));
        end
        rst = 1'b0;
        mem_ready = 1'b0;
    endtask

    task automatic test_addi();
        ent_t ent; outs_t e, got; int cyc = 0;
        push(6'b000001, 1, 0, 0, fetch_v(1), All);
        push(6'b000001, 1, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b000001;
        push(6'b000001, 1, 0, 0, e, All);
        e = base_v(0); e.reg_write = 1'b1;
        push(6'b000001, 1, 0, 0, e, All);
        push(6'b000001, 0, 0, 0, fetch_v(0), All);  // cycle 5: back in FETCH
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL addi cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ld_wait();
        ent_t ent; outs_t e, got; int cyc = 0;
        push(6'b001010, 1, 0, 0, fetch_v(1), All);
        push(6'b001010, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b001010;
        push(6'b001010, 0, 0, 0, e, All);
        e = base_v(0); e.mem_req = 1'b1; e.addr_sel = 2'b01;
        for (int i = 0; i < 4; i++) push(6'b001010, (i == 3), 0, 0, e, All);
        e = base_v(0); e.reg_write = 1'b1; e.wb_sel = 2'b01;
        push(6'b001010, 0, 0, 0, e, All);
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL ld_wait cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branches();
        ent_t ent; outs_t e, got, c; int cyc = 0;
        c = All; c.pc_sel = 2'b00;  // select is irrelevant when the branch is not taken
        // BZ taken (flags opposite in DECODE to show they are only used in EXEC)
        push(6'b010001, 1, 0, 0, fetch_v(1), All);
        push(6'b010001, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b010001; e.pc_write = 1'b1; e.pc_sel = 2'b01;
        push(6'b010001, 0, 0, 1, e, All);
        // BZ not taken
        push(6'b010001, 1, 0, 1, fetch_v(1), All);
        push(6'b010001, 0, 0, 1, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b010001;
        push(6'b010001, 0, 0, 0, e, c);
        // BPL taken with n = 0, z = 0
        push(6'b010000, 1, 0, 0, fetch_v(1), All);
        push(6'b010000, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b010000; e.pc_write = 1'b1; e.pc_sel = 2'b01;
        push(6'b010000, 0, 0, 0, e, All);
        // BMI not taken with n = 0 (z = 1 must not matter)
        push(6'b001111, 1, 0, 0, fetch_v(1), All);
        push(6'b001111, 0, 1, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b001111;
        push(6'b001111, 0, 0, 1, e, c);
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL branches cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
        flag_n = 1'b0; flag_z = 1'b0;
    endtask

    task automatic test_stack();
        ent_t ent; outs_t e, got, c; int cyc = 0;
        c = All; c.pc_sel = 2'b00;
        // CALL with one wait cycle in MEM
        push(6'b010100, 1, 0, 0, fetch_v(1), All);
        push(6'b010100, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b010100; e.sp_write = 1'b1; e.sp_dec = 1'b1;
        push(6'b010100, 0, 0, 0, e, All);
        e = base_v(0); e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 2'b10;
        push(6'b010100, 0, 0, 0, e, c);
        e.pc_write = 1'b1; e.pc_sel = 2'b01;
        push(6'b010100, 1, 0, 0, e, All);
        // RET
        push(6'b010101, 1, 0, 0, fetch_v(1), All);
        push(6'b010101, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.mem_req = 1'b1; e.addr_sel = 2'b10;
        push(6'b010101, 1, 0, 0, e, All);
        e = base_v(0); e.sp_write = 1'b1; e.pc_write = 1'b1; e.pc_sel = 2'b10;
        push(6'b010101, 0, 0, 0, e, All);
        // POP
        push(6'b010011, 1, 0, 0, fetch_v(1), All);
        push(6'b010011, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.mem_req = 1'b1; e.addr_sel = 2'b10;
        push(6'b010011, 1, 0, 0, e, All);
        e = base_v(0); e.reg_write = 1'b1; e.wb_sel = 2'b01; e.sp_write = 1'b1;
        push(6'b010011, 0, 0, 0, e, All);
        // PUSH
        push(6'b010010, 1, 0, 0, fetch_v(1), All);
        push(6'b010010, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b010010; e.sp_write = 1'b1; e.sp_dec = 1'b1;
        push(6'b010010, 0, 0, 0, e, All);
        e = base_v(0); e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 2'b10;
        push(6'b010010, 1, 0, 0, e, c);
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL stack cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    // mem_ready arrives exactly in the 4th wait cycle: completion, no error.
    task automatic test_fetch_boundary();
        ent_t ent; outs_t e, got; int cyc = 0;
        for (int i = 0; i < 3; i++) push(6'b000011, 0, 0, 0, fetch_v(0), All);
        push(6'b000011, 1, 0, 0, fetch_v(1), All);
        push(6'b000011, 0, 0, 0, base_v(0), All);
        e = base_v(0); e.alu_op = 6'b000011;
        push(6'b000011, 0, 0, 0, e, All);
        e = base_v(0); e.reg_write = 1'b1;
        push(6'b000011, 0, 0, 0, e, All);
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL fetch_boundary cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        ent_t ent; outs_t e, got; int cyc = 0;
        for (int i = 0; i < 4; i++) push(6'b000001, 0, 0, 0, fetch_v(0), All);
        e = base_v(2'b01); e.halted = 1'b1;
        push(6'b000001, 0, 0, 0, e, All);
        push(6'b000001, 1, 0, 0, e, All);  // late mem_ready must not revive it
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL timeout cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_halt_reset();
        ent_t ent; outs_t e, got; int cyc = 0;
        // Reset out of the timeout HALT: outputs and sticky err return to reset values.
        rst = 1'b1;
        #1;
        got = observe();
        n_checks++;
        if (got !== base_v(2'b00)) begin
            n_errors++;
            $display("FAIL halt_reset: got %h, expected %h", got, base_v(2'b00));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // HALT opcode, then sit in HALT with err still clear.
        push(6'b100000, 1, 0, 0, fetch_v(1), All);
        push(6'b100000, 0, 0, 0, base_v(0), All);
        e = base_v(2'b00); e.halted = 1'b1;
        push(6'b100000, 0, 0, 0, e, All);
        push(6'b100000, 1, 0, 0, e, All);
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL halt_opcode cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        // Mid-request reset drops mem_req without waiting for a clock edge.
        #2;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL req_before_async_rst: mem_req %b, expected 1", mem_req);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL async_rst_drop: mem_req %b, expected 0", mem_req);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_illegal();
        ent_t ent; outs_t e, got; int cyc = 0;
        push(6'b111000, 1, 0, 0, fetch_v(1), All);
        push(6'b111000, 0, 0, 0, base_v(0), All);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        e = base_v(2'b10); e.halted = 1'b1;
        push(6'b111000, 0, 0, 0, e, All);
        push(6'b111000, 1, 0, 0, e, All);
`else
        e = fetch_v(0);
        push(6'b111000, 0, 0, 0, e, All);
`endif
        while (sb_q.size() > 0) begin
            ent = sb_q.pop_front();
            opcode = ent.op; mem_ready = ent.ready; flag_n = ent.n; flag_z = ent.z;
            #4;
            got = observe();
            n_checks++;
            if ((got & ent.care) !== (ent.exp & ent.care)) begin
                n_errors++;
                $display("FAIL illegal cycle %0d: got %h, expected %h (care %h)",
                         cyc, got, ent.exp, ent.care);
            end
            cyc++;
            @(posedge clk); #1;
        end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        rst = 1'b1;
        #1;
        got = observe();
        n_checks++;
        if (got !== base_v(2'b00)) begin
            n_errors++;
            $display("FAIL illegal_reset: got %h, expected %h", got, base_v(2'b00));
        end
        @(posedge clk); #1;
        rst = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_addi();
        test_ld_wait();
        test_branches();
        test_stack();
        test_fetch_boundary();
        test_timeout();
        test_halt_reset();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle main control unit for the processor datapath. Sequences every instruction through fetch, decode, execute, memory and writeback. Drives all datapath enables, and drives the 6-bit ALU operation code consumed by the ALU controller. Owns the memory request handshake, including a stall watchdog, and the HALT state.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum wait cycles for `mem_ready` per request, range 1–255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward.
- flag_n, flag_z  in  1 each  ALU negative/zero flags, registered by the datapath.
- mem_ready  in  1  memory completes the current request this cycle.
- alu_op  out  6  opcode forwarded to the ALU controller in EXEC; 6'b111111 otherwise.
- ir_write, pc_write, reg_write, sp_write  out  1 each  register write enables.
- pc_sel  out  2  00 PC+1, 01 ALU result, 10 memory read data.
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC.
- sp_dec  out  1  with `sp_write`: 1 = SP-1, 0 = SP+1.
- mem_req, mem_we  out  1 each  memory request and write strobe.
- addr_sel  out  2  00 PC, 01 ALU result, 10 SP.
- halted  out  1  HALT state reached.
- err  out  2  00 none, 01 memory timeout, 10 illegal opcode.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- All outputs are Moore, except enables gated by `mem_ready` or by flags.
- Reset: state FETCH, wait counter 0, `alu_op` = 6'b111111, every other output 0.
- FETCH:
  - `mem_req` = 1, `addr_sel` = 00.
  - On `mem_ready`: `ir_write` = 1, `pc_write` = 1 with `pc_sel` = 00, then go to DECODE.
- DECODE: one cycle, no enables. Next state:
  - R-type (000000), ALU-immediate (000001–001001), MOVE (010110), LD/ST/LDSP/STSP (001010–001101), branches (001110–010001), PUSH (010010), CALL (010100): go to EXEC.
  - POP (010011), RET (010101): go to MEM.
  - HALT (100000): go to HALT.
- EXEC: `alu_op` = opcode. Per opcode:
  - ALU ops and MOVE: go to WB.
  - LD/ST/LDSP/STSP: go to MEM.
  - BR: `pc_write` = 1, `pc_sel` = 01.
  - BMI: `pc_write` = `flag_n`.
  - BPL: `pc_write` = !`flag_n` & !`flag_z`.
  - BZ: `pc_write` = `flag_z`.
  - All branches then go to FETCH.
  - PUSH/CALL: `sp_write` = 1, `sp_dec` = 1, then go to MEM.
- MEM:
  - `mem_req` = 1.
  - `addr_sel`: 10 for PUSH/POP/CALL/RET, 01 otherwise.
  - `mem_we` = 1 for ST/STSP/PUSH/CALL.
  - On `mem_ready`:
    - Loads/POP/RET: go to WB.
    - ST/STSP/PUSH: go to FETCH.
    - CALL: `pc_write` = 1, `pc_sel` = 01, then go to FETCH.
  - The datapath supplies the PC as CALL store data.
- WB:
  - `reg_write` = 1 except for RET.
  - `wb_sel`: 01 for LD/LDSP/POP, 00 otherwise.
  - POP/RET: `sp_write` = 1, `sp_dec` = 0.
  - RET: `pc_write` = 1, `pc_sel` = 10.
  - Then go to FETCH.
- HALT: `halted` = 1, all enables 0. Exited only by `rst`.
- Wait counter (8-bit):
  - Clears on entering FETCH or MEM.
  - Increments each cycle `mem_req` = 1 and `mem_ready` = 0.
  - Reaching MEM_TIMEOUT: `err` = 01, go to HALT, suppress all enables that cycle.
- `mem_ready` in the same cycle the counter reaches MEM_TIMEOUT: completion wins, no error.
- `err` is sticky until `rst`.

## Timing
- Latency with zero-wait memory (`mem_ready` high on the first request cycle):
  - ALU/MOVE: 4 cycles.
  - Branch: 3 cycles.
  - ST/PUSH/CALL: 4 cycles.
  - LD: 5 cycles.
  - POP/RET: 4 cycles.
- Each wait cycle adds 1.
- `mem_req` holds high and `addr_sel`/`mem_we` hold stable until `mem_ready` is sampled high.
- `mem_req` deasserts the cycle after completion.
- `mem_ready` outside FETCH/MEM is ignored.
- Flags are sampled in the EXEC cycle only.
- `rst` mid-request drops `mem_req` immediately (asynchronously); the memory must discard the request.

## Configuration
- MAIN_CTRL_ILLEGAL_TRAP_EN defined: an opcode outside the listed set goes from DECODE to HALT with `err` = 10.
- Undefined: such an opcode is a NOP; DECODE returns to FETCH and `err` stays 00.

## Test plan
- Reset, then ADDI (000001) with `mem_ready` tied high:
  - FETCH→DECODE→EXEC→WB, `alu_op` = 000001 in EXEC only.
  - `reg_write` = 1 in cycle 4, back in FETCH at cycle 5.
- LD (001010) with `mem_ready` delayed 3 cycles in MEM: `mem_req` = 1 with `addr_sel` = 01 for 4 cycles, then WB with `wb_sel` = 01.
- BZ (010001) issued twice, once with `flag_z` = 1 and once with 0: `pc_write` = 1 with `pc_sel` = 01 in the first EXEC, 0 in the second.
- CALL (010100) then RET (010101):
  - CALL: `sp_write` = 1 with `sp_dec` = 1 in EXEC; `mem_we` = 1 with `addr_sel` = 10; `pc_sel` = 01 on completion.
  - RET: `pc_sel` = 10 and `sp_dec` = 0 in WB.
- MEM_TIMEOUT = 4, `mem_ready` stuck 0 in FETCH: after 4 wait cycles `halted` = 1 and `err` = 01. Check again with `mem_ready` = 1 exactly on the 4th wait cycle: normal completion.
- Opcode 111000 with and without MAIN_CTRL_ILLEGAL_TRAP_EN: HALT with `err` = 10 versus return to FETCH. Assert `rst` during HALT: all outputs return to their reset values.
